sprite_table: RTL and testbench

Double-buffered sprite attribute table for the GPU sprite cluster. It is an AXI4-Lite write-only slave that collects per-sprite attributes into a shadow copy. On a software commit request, it transfers the whole shadow copy to the active copy at the next frame start, so the cluster never renders a half-updated frame. The active-copy outputs drive the cluster's `sx/sy/stx/sty/stw/sth/ssc` arrays, replacing the fixed sprite setup in the GPU top level.

---
 rtl/gpu_pkg.sv | 62 ++++++
 rtl/axil_write_slave.sv | 114 +++++++++++
 rtl/sprite_table.sv | 198 +++++++++++++++++++
 tb/tb_sprite_table.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// -----------------------------------------------------------------------------
// gpu_pkg
// Shared definitions for the sprite attribute table: register map constants,
// AXI response codes, the packed per-sprite attribute record and its reset
// value, plus a byte-enable merge helper used by every writable register.
// -----------------------------------------------------------------------------
package gpu_pkg;

    // Field widths of one sprite record (position words and packed shorts).
    localparam int SPRITE_DW = 32;
    localparam int SPRITE_SW = 8;

    // Register map.
    localparam int SPRITE_STRIDE = 16;
    localparam int CTRL_ADDR     = 'h800;

    // Byte offsets of the fields inside one sprite's 16-byte slot.
    localparam logic [3:0] OFS_SX    = 4'h0;
    localparam logic [3:0] OFS_SY    = 4'h4;
    localparam logic [3:0] OFS_TEX   = 4'h8;
    localparam logic [3:0] OFS_SCALE = 4'hC;

    // AXI write responses.
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic [SPRITE_DW-1:0] sx;
        logic [SPRITE_DW-1:0] sy;
        logic [SPRITE_SW-1:0] stx;
        logic [SPRITE_SW-1:0] sty;
        logic [SPRITE_SW-1:0] stw;
        logic [SPRITE_SW-1:0] sth;
        logic [SPRITE_SW-1:0] ssc;
    } sprite_t;

    // Scale defaults to 1 so an unprogrammed sprite renders at native size.
    localparam sprite_t SPRITE_RESET = '{
        sx:  '0,
        sy:  '0,
        stx: '0,
        sty: '0,
        stw: '0,
        sth: '0,
        ssc: 8'd1
    };

    // Replace only the bytes of old_word whose strobe bit is set.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] result;
        result = old_word;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                result[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/axil_write_slave.sv
// -----------------------------------------------------------------------------
// axil_write_slave
// AXI4-Lite write-only slave front end. AW and W are each captured into a
// one-entry holding register independently, so any skew between the two
// channels is tolerated. Once both are held, a single-cycle write strobe
// {we, addr, data, strb} is presented to the register file, which answers
// with err in the same cycle; the response is then held on B until bready.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   awaddr/awvalid/awready    write address channel
//   wdata/wstrb/wvalid/wready write data channel
//   bresp/bvalid/bready       write response channel
//   we, addr, data, strb      one-cycle write strobe to the register file
//   err                       register file decode error for the current we
// -----------------------------------------------------------------------------
module axil_write_slave
    import gpu_pkg::*;
#(
    parameter int ADDR_WIDTH = 24,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [STRB_WIDTH-1:0] wstrb,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] data,
    output logic [STRB_WIDTH-1:0] strb,
    input  logic                  err
);

    logic                  aw_full_q, aw_full_d;
    logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
    logic                  w_full_q,  w_full_d;
    logic [DATA_WIDTH-1:0] w_data_q,  w_data_d;
    logic [STRB_WIDTH-1:0] w_strb_q,  w_strb_d;
    logic                  bvalid_q,  bvalid_d;
    logic [1:0]            bresp_q,   bresp_d;

    // A pending response blocks both channels so at most one write is in
    // flight and the holding registers cannot refill under an unread B.
    assign awready = !aw_full_q && !bvalid_q;
    assign wready  = !w_full_q  && !bvalid_q;

    assign we   = aw_full_q && w_full_q && !bvalid_q;
    assign addr = aw_addr_q;
    assign data = w_data_q;
    assign strb = w_strb_q;

    assign bvalid = bvalid_q;
    assign bresp  = bresp_q;

    always_comb begin
        aw_full_d = aw_full_q;
        aw_addr_d = aw_addr_q;
        w_full_d  = w_full_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;

        if (awvalid && awready) begin
            aw_full_d = 1'b1;
            aw_addr_d = awaddr;
        end
        if (wvalid && wready) begin
            w_full_d = 1'b1;
            w_data_d = wdata;
            w_strb_d = wstrb;
        end

        // we implies both ready signals are low, so no capture collides here.
        if (we) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = err ? RESP_SLVERR : RESP_OKAY;
        end else if (bvalid_q && bready) begin
            bvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_full_q <= 1'b0;
            aw_addr_q <= '0;
            w_full_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            aw_full_q <= aw_full_d;
            aw_addr_q <= aw_addr_d;
            w_full_q  <= w_full_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
        end
    end

endmodule

// File: rtl/sprite_table.sv
// -----------------------------------------------------------------------------
// sprite_table
// Double-buffered sprite attribute table. Software writes attributes into a
// shadow copy over AXI4-Lite, then writes CTRL bit 0 to arm a commit. The
// whole shadow copy is transferred to the active copy on the next
// frame_start, so the sprite cluster only ever sees complete frames.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   aw*/w*/b*              AXI4-Lite write-only slave (awprot ignored)
//   frame_start            one-cycle pulse at start of vertical blanking
//   sx, sy                 active sprite positions, one word per sprite
//   stx, sty, stw, sth     active texture origin and size
//   ssc                    active scale
//   commit_pending         a commit is armed, waiting for frame_start
//   committed              high in the cycle whose edge updates the active copy
// -----------------------------------------------------------------------------
module sprite_table
    import gpu_pkg::*;
#(
    parameter int CLUSTER_SIZE = 10,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 24,
    parameter int STRB_WIDTH   = DATA_WIDTH / 8,
    parameter int SHORT_WIDTH  = DATA_WIDTH / 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_WIDTH-1:0]  awaddr,
    input  logic [2:0]             awprot,
    input  logic                   awvalid,
    output logic                   awready,
    input  logic [DATA_WIDTH-1:0]  wdata,
    input  logic [STRB_WIDTH-1:0]  wstrb,
    input  logic                   wvalid,
    output logic                   wready,
    output logic [1:0]             bresp,
    output logic                   bvalid,
    input  logic                   bready,
    input  logic                   frame_start,
    output logic [DATA_WIDTH-1:0]  sx  [CLUSTER_SIZE],
    output logic [DATA_WIDTH-1:0]  sy  [CLUSTER_SIZE],
    output logic [SHORT_WIDTH-1:0] stx [CLUSTER_SIZE],
    output logic [SHORT_WIDTH-1:0] sty [CLUSTER_SIZE],
    output logic [SHORT_WIDTH-1:0] stw [CLUSTER_SIZE],
    output logic [SHORT_WIDTH-1:0] sth [CLUSTER_SIZE],
    output logic [SHORT_WIDTH-1:0] ssc [CLUSTER_SIZE],
    output logic                   commit_pending,
    output logic                   committed
);

    localparam int IDX_W = (CLUSTER_SIZE > 1) ? $clog2(CLUSTER_SIZE) : 1;
    localparam logic [ADDR_WIDTH-1:0] CTRL_A   = ADDR_WIDTH'(CTRL_ADDR);
    localparam logic [ADDR_WIDTH-1:0] SPRITE_END =
        ADDR_WIDTH'(CLUSTER_SIZE * SPRITE_STRIDE);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ARMED = 1'b1;

    // Protection attributes carry no meaning for this register file.
    logic unused_awprot;
    assign unused_awprot = ^awprot;

    // ------------------------------------------------------------------
    // AXI front end
    // ------------------------------------------------------------------
    logic                  wr_we;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [STRB_WIDTH-1:0] wr_strb;
    logic                  wr_err;

    axil_write_slave #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .STRB_WIDTH (STRB_WIDTH)
    ) u_axil (
        .clk     (clk),
        .rst     (rst),
        .awaddr  (awaddr),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wvalid  (wvalid),
        .wready  (wready),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready),
        .we      (wr_we),
        .addr    (wr_addr),
        .data    (wr_data),
        .strb    (wr_strb),
        .err     (wr_err)
    );

    // ------------------------------------------------------------------
    // Address decode (byte address, bits [1:0] ignored)
    // ------------------------------------------------------------------
    logic             is_ctrl;
    logic             is_sprite;
    logic [IDX_W-1:0] wr_idx;
    logic [3:0]       field_ofs;
    logic             wr_sprite;
    logic             ctrl_arm;

    assign is_ctrl   = (wr_addr[ADDR_WIDTH-1:2] == CTRL_A[ADDR_WIDTH-1:2]);
    // CLUSTER_SIZE is at most 128, so the sprite window never reaches CTRL.
    assign is_sprite = (wr_addr < SPRITE_END);
    assign wr_idx    = wr_addr[4 +: IDX_W];
    assign field_ofs = {wr_addr[3:2], 2'b00};
    assign wr_err    = !(is_ctrl || is_sprite);

    assign wr_sprite = wr_we && is_sprite;
    assign ctrl_arm  = wr_we && is_ctrl && wr_strb[0] && wr_data[0];

    // ------------------------------------------------------------------
    // Commit state machine
    // ------------------------------------------------------------------
    logic [0:0] state_q, state_d;
    logic       commit_fire;

    assign commit_fire    = (state_q == ST_ARMED) && frame_start;
    assign commit_pending = (state_q == ST_ARMED);
    assign committed      = commit_fire;

    // An arm arriving in the same cycle as a copy refers to writes after the
    // snapshot, so it wins and the table stays armed for the next frame.
    always_comb begin
        state_d = state_q;
        if (commit_fire) begin
            state_d = ST_IDLE;
        end
        if (ctrl_arm) begin
            state_d = ST_ARMED;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Per-sprite shadow and active copies
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < CLUSTER_SIZE; gi++) begin : g_sprite
        sprite_t shadow_q, shadow_d;
        sprite_t active_q, active_d;
        logic    sel;

        assign sel = wr_sprite && (wr_idx == IDX_W'(gi));

        always_comb begin
            shadow_d = shadow_q;
            if (sel) begin
                case (field_ofs)
                    OFS_SX:  shadow_d.sx = merge_bytes(shadow_q.sx, wr_data, wr_strb);
                    OFS_SY:  shadow_d.sy = merge_bytes(shadow_q.sy, wr_data, wr_strb);
                    OFS_TEX: {shadow_d.stx, shadow_d.sty, shadow_d.stw, shadow_d.sth} =
                                 merge_bytes({shadow_q.stx, shadow_q.sty,
                                              shadow_q.stw, shadow_q.sth},
                                             wr_data, wr_strb);
                    OFS_SCALE: begin
                        if (wr_strb[0]) begin
                            shadow_d.ssc = wr_data[7:0];
                        end
                    end
                    default: ;
                endcase
            end
            // The copy takes the pre-write shadow value on a colliding write.
            active_d = commit_fire ? shadow_q : active_q;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                shadow_q <= SPRITE_RESET;
                active_q <= SPRITE_RESET;
            end else begin
                shadow_q <= shadow_d;
                active_q <= active_d;
            end
        end

        assign sx[gi]  = active_q.sx;
        assign sy[gi]  = active_q.sy;
        assign stx[gi] = active_q.stx;
        assign sty[gi] = active_q.sty;
        assign stw[gi] = active_q.stw;
        assign sth[gi] = active_q.sth;
        assign ssc[gi] = active_q.ssc;
    end

endmodule

// File: tb/tb_sprite_table.sv
// -----------------------------------------------------------------------------
// tb_sprite_table
// Self-checking bench for sprite_table: a directed vector table, hand-written
// collision / backpressure / reset sequences, then randomized traffic checked
// against a word-level model of the shadow and active tables.
// -----------------------------------------------------------------------------
module tb_sprite_table;

    localparam int N = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic        frame_start;
    logic [31:0] sx  [N];
    logic [31:0] sy  [N];
    logic [7:0]  stx [N];
    logic [7:0]  sty [N];
    logic [7:0]  stw [N];
    logic [7:0]  sth [N];
    logic [7:0]  ssc [N];
    logic        commit_pending;
    logic        committed;

    always #5 clk = ~clk;

    sprite_table #(.CLUSTER_SIZE(N)) dut (
        .clk            (clk),
        .rst            (rst),
        .awaddr         (awaddr),
        .awprot         (awprot),
        .awvalid        (awvalid),
        .awready        (awready),
        .wdata          (wdata),
        .wstrb          (wstrb),
        .wvalid         (wvalid),
        .wready         (wready),
        .bresp          (bresp),
        .bvalid         (bvalid),
        .bready         (bready),
        .frame_start    (frame_start),
        .sx             (sx),
        .sy             (sy),
        .stx            (stx),
        .sty            (sty),
        .stw            (stw),
        .sth            (sth),
        .ssc            (ssc),
        .commit_pending (commit_pending),
        .committed      (committed)
    );

    // ------------------------------------------------------------------
    // Reference model: each sprite is four 32-bit words as seen on the bus
    // (sx, sy, packed texture word, scale word whose low byte is ssc).
    // ------------------------------------------------------------------
    logic [31:0] m_sh [N][4];
    logic [31:0] m_ac [N][4];
    bit          m_pend;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            for (int f = 0; f < 4; f++) begin
                m_sh[k][f] = (f == 3) ? 32'd1 : 32'd0;
                m_ac[k][f] = (f == 3) ? 32'd1 : 32'd0;
            end
        end
        m_pend = 0;
    endtask

    task automatic model_write(input logic [23:0] a, input logic [31:0] d,
                               input logic [3:0] s, output logic [1:0] resp);
        int k, f;
        resp = 2'b00;
        if ((a >> 2) == 24'h200) begin
            if (s[0] && d[0]) m_pend = 1;
        end else if (a < N * 16) begin
            k = int'(a) / 16;
            f = (int'(a) % 16) / 4;
            for (int b = 0; b < 4; b++)
                if (s[b]) m_sh[k][f][8*b +: 8] = d[8*b +: 8];
        end else begin
            resp = 2'b10;
        end
    endtask

    task automatic model_frame(output bit comm);
        comm = m_pend;
        if (m_pend) begin
            for (int k = 0; k < N; k++)
                for (int f = 0; f < 4; f++)
                    m_ac[k][f] = m_sh[k][f];
            m_pend = 0;
        end
    endtask

    // Compare every active output and the pending flag to the model.
    task automatic chk_state(input string tag);
        for (int k = 0; k < N; k++) begin
            chk($sformatf("%s active[%0d]", tag, k),
                {sx[k], sy[k], stx[k], sty[k], stw[k], sth[k], ssc[k]},
                {m_ac[k][0], m_ac[k][1], m_ac[k][2], m_ac[k][3][7:0]});
        end
        chk({tag, " commit_pending"}, commit_pending, m_pend);
    endtask

    // ------------------------------------------------------------------
    // Bus tasks. All enter and leave at posedge+1.
    // ------------------------------------------------------------------
    task automatic axi_write(input logic [23:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, input int b_dly,
                             output logic [1:0] resp);
        bit aw_done = 0, w_done = 0, b_done = 0;
        bit aw_hs, w_hs, b_hs;
        int bcnt = 0;
        int cyc  = 0;
        logic [1:0] r = 2'bxx;
        while (!b_done && cyc < 200) begin
            awaddr  = a;
            wdata   = d;
            wstrb   = s;
            awvalid = !aw_done && (cyc >= aw_dly);
            wvalid  = !w_done  && (cyc >= w_dly);
            bready  = (bcnt >= b_dly);
            @(negedge clk);
            if (bvalid) begin
                chk("ready_low_while_bvalid", {awready, wready}, 2'b00);
                bcnt++;
            end
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            b_hs  = bvalid && bready;
            if (b_hs) r = bresp;
            @(posedge clk); #1;
            if (aw_hs) aw_done = 1;
            if (w_hs)  w_done  = 1;
            if (b_hs)  b_done  = 1;
            cyc++;
        end
        awvalid = 0;
        wvalid  = 0;
        bready  = 0;
        if (!b_done) begin
            n_checks++;
            n_fail++;
            $display("FAIL write_timeout: addr %0h got no response, required one within 200 cycles", a);
        end
        resp = r;
        @(negedge clk);
        chk("single_response", bvalid, 1'b0);
        chk("ready_restored", {awready, wready}, 2'b11);
        @(posedge clk); #1;
    endtask

    task automatic do_frame(output bit comm);
        frame_start = 1;
        @(negedge clk);
        comm = committed;
        @(posedge clk); #1;
        frame_start = 0;
    endtask

    // Write whose execute cycle coincides with a frame_start pulse.
    task automatic collide(input logic [23:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output bit comm);
        awaddr  = a;
        wdata   = d;
        wstrb   = s;
        awvalid = 1;
        wvalid  = 1;
        bready  = 1;
        @(posedge clk); #1;
        awvalid = 0;
        wvalid  = 0;
        frame_start = 1;
        @(negedge clk);
        comm = committed;
        @(posedge clk); #1;
        frame_start = 0;
        @(negedge clk);
        chk("collide_bvalid", bvalid, 1'b1);
        resp = bresp;
        @(posedge clk); #1;
        bready = 0;
    endtask

    // ------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------
    typedef struct {
        bit          is_frame;
        logic [23:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic [1:0]  exp_resp;
        bit          exp_comm;
    } vec_t;

    vec_t vt [15];

    initial begin
        logic [1:0] r, mr;
        bit c, mc;

        vt[0]  = '{0, 24'h000, 32'h0000_0064, 4'hF, 2'b00, 0};
        vt[1]  = '{1, 24'h000, 32'h0,         4'h0, 2'b00, 0};
        vt[2]  = '{0, 24'h010, 32'h0000_012C, 4'hF, 2'b00, 0};
        vt[3]  = '{0, 24'h018, 32'h0000_4040, 4'hF, 2'b00, 0};
        vt[4]  = '{0, 24'h800, 32'h0000_0001, 4'hF, 2'b00, 0};
        vt[5]  = '{1, 24'h000, 32'h0,         4'h0, 2'b00, 1};
        vt[6]  = '{0, 24'h00C, 32'hFFFF_FF02, 4'h1, 2'b00, 0};
        vt[7]  = '{0, 24'h803, 32'h0000_0001, 4'h1, 2'b00, 0};
        vt[8]  = '{1, 24'h000, 32'h0,         4'h0, 2'b00, 1};
        vt[9]  = '{0, 24'h0A0, 32'hDEAD_BEEF, 4'hF, 2'b10, 0};
        vt[10] = '{0, 24'h800, 32'h0000_0000, 4'hF, 2'b00, 0};
        vt[11] = '{1, 24'h000, 32'h0,         4'h0, 2'b00, 0};
        vt[12] = '{0, 24'h804, 32'h0000_0001, 4'hF, 2'b10, 0};
        vt[13] = '{0, 24'h800, 32'h0000_0001, 4'hE, 2'b00, 0};
        vt[14] = '{1, 24'h000, 32'h0,         4'h0, 2'b00, 0};

        rst = 1; awaddr = 0; awprot = 0; awvalid = 0; wdata = 0; wstrb = 0;
        wvalid = 0; bready = 0; frame_start = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 0;

        // Reset state.
        @(negedge clk);
        chk_state("reset");
        chk("reset ssc[0]", ssc[0], 8'd1);
        chk("reset ready", {awready, wready}, 2'b11);
        chk("reset bvalid/bresp", {bvalid, bresp}, 3'b000);
        chk("reset committed", committed, 1'b0);
        @(posedge clk); #1;

        // Directed table.
        for (int i = 0; i < 15; i++) begin
            if (vt[i].is_frame) begin
                do_frame(c);
                model_frame(mc);
                chk($sformatf("vec%0d committed", i), c, vt[i].exp_comm);
                $display("vec %0d: frame_start committed=%0d", i, c);
            end else begin
                axi_write(vt[i].a, vt[i].d, vt[i].s, 0, 0, 0, r);
                model_write(vt[i].a, vt[i].d, vt[i].s, mr);
                chk($sformatf("vec%0d bresp", i), r, vt[i].exp_resp);
                $display("vec %0d: write %06h <= %08h strb %h bresp=%b", i, vt[i].a, vt[i].d, vt[i].s, r);
            end
            @(negedge clk);
            chk_state($sformatf("vec%0d", i));
            @(posedge clk); #1;
        end
        chk("sx[0]", sx[0], 32'h64);
        chk("sx[1]", sx[1], 32'd300);
        chk("stw[1]", stw[1], 8'd64);
        chk("sth[1]", sth[1], 8'd64);
        chk("ssc[0]", ssc[0], 8'd2);

        // CTRL write colliding with frame_start while idle: arm, no copy.
        axi_write(24'h020, 32'h0000_AAAA, 4'hF, 0, 0, 0, r);
        model_write(24'h020, 32'h0000_AAAA, 4'hF, mr);
        collide(24'h800, 32'h1, 4'hF, r, c);
        model_frame(mc);
        model_write(24'h800, 32'h1, 4'hF, mr);
        $display("collide ctrl: committed=%0d bresp=%b", c, r);
        chk("collide_ctrl committed", c, 1'b0);
        chk("collide_ctrl bresp", r, 2'b00);
        chk("collide_ctrl pending", commit_pending, 1'b1);
        chk("collide_ctrl sx[2]", sx[2], 32'h0);

        // Shadow write colliding with the copy: active gets the old value.
        collide(24'h020, 32'h0000_BBBB, 4'hF, r, c);
        model_frame(mc);
        model_write(24'h020, 32'h0000_BBBB, 4'hF, mr);
        $display("collide shadow: committed=%0d bresp=%b", c, r);
        chk("collide_shadow committed", c, 1'b1);
        chk("collide_shadow sx[2]", sx[2], 32'h0000_AAAA);
        axi_write(24'h800, 32'h1, 4'hF, 0, 0, 0, r);
        model_write(24'h800, 32'h1, 4'hF, mr);
        do_frame(c);
        model_frame(mc);
        chk("collide_followup committed", c, 1'b1);
        chk("collide_followup sx[2]", sx[2], 32'h0000_BBBB);

        // W five cycles ahead of AW, response held off for three cycles.
        axi_write(24'h094, 32'hCAFE_0123, 4'hF, 5, 0, 3, r);
        model_write(24'h094, 32'hCAFE_0123, 4'hF, mr);
        $display("backpressure write: bresp=%b", r);
        chk("backpressure bresp", r, 2'b00);
        axi_write(24'h800, 32'h1, 4'hF, 0, 0, 0, r);
        model_write(24'h800, 32'h1, 4'hF, mr);
        do_frame(c);
        model_frame(mc);
        chk("backpressure sy[9]", sy[9], 32'hCAFE_0123);

        // Randomized traffic against the model.
        for (int i = 0; i < 80; i++) begin
            int op;
            logic [23:0] a;
            logic [31:0] d;
            logic [3:0]  s;
            op = $urandom_range(0, 11);
            d  = $urandom;
            s  = 4'($urandom_range(0, 15));
            if (op <= 5)
                a = 24'($urandom_range(0, N - 1) * 16 + $urandom_range(0, 15));
            else if (op <= 7) begin
                a = 24'(32'h800 + $urandom_range(0, 3));
                d[0] = ($urandom_range(0, 3) != 0);
            end else
                a = ($urandom_range(0, 1) != 0) ? 24'($urandom_range(N * 16, 'h7FF))
                                                : 24'($urandom_range('h804, 'hFFFF));
            if (op == 9) begin
                do_frame(c);
                model_frame(mc);
                chk("rand committed", c, mc);
                $display("rand %0d: frame_start committed=%0d", i, c);
            end else if (op == 10) begin
                collide(a, d, s, r, c);
                model_frame(mc);
                model_write(a, d, s, mr);
                chk("rand collide committed", c, mc);
                chk("rand collide bresp", r, mr);
                $display("rand %0d: collide %06h <= %08h strb %h bresp=%b committed=%0d", i, a, d, s, r, c);
            end else begin
                axi_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3),
                          $urandom_range(0, 3), r);
                model_write(a, d, s, mr);
                chk("rand bresp", r, mr);
                $display("rand %0d: write %06h <= %08h strb %h bresp=%b", i, a, d, s, r);
            end
            @(negedge clk);
            chk_state("rand");
            @(posedge clk); #1;
        end

        // Reset while a write sits in the holding registers: no response.
        awaddr = 24'h000; wdata = 32'h1234; wstrb = 4'hF;
        awvalid = 1; wvalid = 1; bready = 0;
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0;
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("midreset bvalid", bvalid, 1'b0);
        end
        chk("midreset ready", {awready, wready}, 2'b11);
        chk_state("midreset");
        $display("mid-transaction reset: bvalid=%0d", bvalid);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
